// File: rtl/code_entry_seq.sv
// Keypad digit collector and debounced ENTER handler that streams a 4-digit code to comb_lock.
// Latency: enter pulse on the cycle after a debounced submit, gap, then digits on 4 consecutive cycles.
// No backpressure: events arriving while streaming or while locked are dropped. Optional ENTRY_TIMEOUT_EN clears stale partial entries.
module code_entry_seq #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned ENTRY_TIMEOUT   = 500_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       submit_raw,
  input  logic       lock_in,
  output logic       enter_button,
  output logic [3:0] ip_pass,
  output logic       busy,
  output logic [2:0] digit_count,
  output logic       entry_err
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {COLLECT, PULSE, GAP, STREAM} state_t;

  logic             sync1, sync2, sync_prev;
  logic [CNT_W-1:0] db_cnt;
  logic             stable, stable_q;
  logic             submit_evt;

  state_t           state;
  logic [1:0]       idx;
  logic [3:0]       dig_buf [4];

`ifdef ENTRY_TIMEOUT_EN
  logic [31:0]      idle_cnt;
`endif

  // Synchronise the raw button and accept a level only after it has held steady long enough.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync_prev <= 1'b0;
      db_cnt    <= '0;
      stable    <= 1'b0;
      stable_q  <= 1'b0;
    end else begin
      sync1     <= submit_raw;
      sync2     <= sync1;
      sync_prev <= sync2;
      stable_q  <= stable;
      if (sync2 != sync_prev)
        db_cnt <= '0;
      else if (db_cnt != CNT_W'(DEBOUNCE_CYCLES))
        db_cnt <= db_cnt + CNT_W'(1);
      if (db_cnt == CNT_W'(DEBOUNCE_CYCLES))
        stable <= sync_prev;
    end
  end

  // Only a press (stable 0->1) submits; the release is silent.
  assign submit_evt = stable & ~stable_q;

  // Entry collection and the pulse/gap/stream sequence toward comb_lock.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= COLLECT;
      idx          <= 2'd0;
      for (int k = 0; k < 4; k++) dig_buf[k] <= 4'd0;
      digit_count  <= 3'd0;
      enter_button <= 1'b0;
      ip_pass      <= 4'd0;
      busy         <= 1'b0;
      entry_err    <= 1'b0;
`ifdef ENTRY_TIMEOUT_EN
      idle_cnt     <= 32'd0;
`endif
    end else begin
      entry_err <= 1'b0;
      case (state)
        COLLECT: begin
          enter_button <= 1'b0;
          ip_pass      <= 4'd0;
          busy         <= 1'b0;
          if (lock_in) begin
            // Locked: wipe any partial code and swallow all events quietly.
            for (int k = 0; k < 4; k++) dig_buf[k] <= 4'd0;
            digit_count <= 3'd0;
`ifdef ENTRY_TIMEOUT_EN
            idle_cnt    <= 32'd0;
`endif
          end else if (submit_evt) begin
            // Submit takes priority over a simultaneous key, which is dropped.
`ifdef ENTRY_TIMEOUT_EN
            idle_cnt <= 32'd0;
`endif
            if (digit_count == 3'd4) begin
              state        <= PULSE;
              enter_button <= 1'b1;
              busy         <= 1'b1;
            end else begin
              entry_err <= 1'b1;
            end
          end else if (key_valid) begin
`ifdef ENTRY_TIMEOUT_EN
            idle_cnt <= 32'd0;
`endif
            if (key_code <= 4'd9) begin
              if (digit_count != 3'd4) begin
                dig_buf[digit_count[1:0]] <= key_code;
                digit_count               <= digit_count + 3'd1;
              end else begin
                entry_err <= 1'b1;
              end
            end else if (key_code == 4'hB) begin
              if (digit_count != 3'd0)
                digit_count <= digit_count - 3'd1;
              else
                entry_err <= 1'b1;
            end else if (key_code == 4'hC) begin
              digit_count <= 3'd0;
            end
          end
`ifdef ENTRY_TIMEOUT_EN
          else if (digit_count != 3'd0) begin
            // Abandoned partial entry: drop it after a long idle spell.
            if (idle_cnt == ENTRY_TIMEOUT - 32'd1) begin
              digit_count <= 3'd0;
              entry_err   <= 1'b1;
              idle_cnt    <= 32'd0;
            end else begin
              idle_cnt <= idle_cnt + 32'd1;
            end
          end
`endif
        end
        PULSE: begin
          enter_button <= 1'b0;
          state        <= GAP;
        end
        GAP: begin
          ip_pass <= dig_buf[0];
          idx     <= 2'd0;
          state   <= STREAM;
        end
        STREAM: begin
          if (idx == 2'd3) begin
            ip_pass     <= 4'd0;
            busy        <= 1'b0;
            digit_count <= 3'd0;
            state       <= COLLECT;
          end else begin
            ip_pass <= dig_buf[idx + 2'd1];
            idx     <= idx + 2'd1;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_code_entry_seq.sv
// Directed bench for code_entry_seq with short debounce and timeout values.
// Traces output windows around each submit and compares against hand-computed sequences.
// Define ENTRY_TIMEOUT_EN to exercise the idle-timeout path instead of the persistence path.
module tb_code_entry_seq;

  logic       clk = 1'b0;
  logic       rst, key_valid, submit_raw, lock_in;
  logic [3:0] key_code;
  logic       enter_button, busy, entry_err;
  logic [3:0] ip_pass;
  logic [2:0] digit_count;

  int n_cmp = 0;
  int n_bad = 0;

  localparam int TW = 40;
  logic       tr_en   [TW];
  logic       tr_err  [TW];
  logic       tr_busy [TW];
  logic [3:0] tr_ip   [TW];
  logic [2:0] tr_cnt  [TW];

  code_entry_seq #(.DEBOUNCE_CYCLES(3), .ENTRY_TIMEOUT(30)) dut (
    .clk          (clk),
    .rst          (rst),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .submit_raw   (submit_raw),
    .lock_in      (lock_in),
    .enter_button (enter_button),
    .ip_pass      (ip_pass),
    .busy         (busy),
    .digit_count  (digit_count),
    .entry_err    (entry_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic press(input logic [3:0] c, output logic err);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = c;
    @(negedge clk);
    err       = entry_err;
    key_valid = 1'b0;
    key_code  = 4'd0;
  endtask

  task automatic press4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                        input logic [3:0] d, output logic any_err);
    logic e;
    any_err = 1'b0;
    press(a, e); any_err |= e;
    press(b, e); any_err |= e;
    press(c, e); any_err |= e;
    press(d, e); any_err |= e;
  endtask

  // Drives a submit_raw waveform (optionally with two bounces) and records outputs each cycle.
  task automatic run_submit(input logic bounce);
    for (int i = 0; i < TW; i++) begin
      @(negedge clk);
      tr_en[i]   = enter_button;
      tr_err[i]  = entry_err;
      tr_busy[i] = busy;
      tr_ip[i]   = ip_pass;
      tr_cnt[i]  = digit_count;
      if (bounce)
        submit_raw = (i < 4) ? ((i % 2) == 0) : (i < 14);
      else
        submit_raw = (i < 10);
    end
    submit_raw = 1'b0;
  endtask

  function automatic int count_en();
    int n = 0;
    for (int i = 0; i < TW; i++) if (tr_en[i]) n++;
    return n;
  endfunction

  function automatic int count_err();
    int n = 0;
    for (int i = 0; i < TW; i++) if (tr_err[i]) n++;
    return n;
  endfunction

  task automatic check_stream(input string tag, input logic [3:0] d0, input logic [3:0] d1,
                              input logic [3:0] d2, input logic [3:0] d3);
    int n = -1;
    for (int i = TW - 1; i >= 0; i--) if (tr_en[i]) n = i;
    check({tag, "_pulses"}, count_en(), 1);
    check({tag, "_errs"}, count_err(), 0);
    if (n >= 0 && n + 6 < TW) begin
      check({tag, "_n_ip"},    tr_ip[n],     0);
      check({tag, "_n1_en"},   tr_en[n+1],   0);
      check({tag, "_n1_ip"},   tr_ip[n+1],   0);
      check({tag, "_d0"},      tr_ip[n+2],   d0);
      check({tag, "_d1"},      tr_ip[n+3],   d1);
      check({tag, "_d2"},      tr_ip[n+4],   d2);
      check({tag, "_d3"},      tr_ip[n+5],   d3);
      check({tag, "_busy_n5"}, tr_busy[n+5], 1);
      check({tag, "_n6_ip"},   tr_ip[n+6],   0);
      check({tag, "_n6_busy"}, tr_busy[n+6], 0);
      check({tag, "_n6_cnt"},  tr_cnt[n+6],  0);
    end else begin
      check({tag, "_stream_found"}, 0, 1);
    end
  endtask

  initial begin
    logic e;
    logic [3:0] t3_keys [7];
    logic       t3_err  [7];
    int found;
    int errs;

    rst = 1'b1; key_valid = 1'b0; key_code = 4'd0; submit_raw = 1'b0; lock_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_enter", enter_button, 0);
    check("rst_ip",    ip_pass, 0);
    check("rst_busy",  busy, 0);
    check("rst_cnt",   digit_count, 0);
    check("rst_err",   entry_err, 0);
    rst = 1'b0;
    repeat (8) @(negedge clk);

    // Backspace on an empty buffer is rejected.
    press(4'hB, e);
    check("bksp_empty_err", e, 1);

    // T1: full code with a bouncy submit.
    press4(4'd1, 4'd5, 4'd3, 4'd7, e);
    check("t1_key_err", e, 0);
    check("t1_cnt", digit_count, 4);
    run_submit(1'b1);
    check_stream("t1", 4'd1, 4'd5, 4'd3, 4'd7);
    check("t1_cnt_after", digit_count, 0);

    // T2: short code submit is rejected and the buffer kept.
    press(4'd1, e); press(4'd5, e);
    run_submit(1'b1);
    check("t2_pulses", count_en(), 0);
    check("t2_errs", count_err(), 1);
    check("t2_cnt", digit_count, 2);
    press(4'hC, e);
    check("clear_err", e, 0);
    check("clear_cnt", digit_count, 0);

    // T3: edits plus an overflow digit.
    t3_keys = '{4'd1, 4'd5, 4'd9, 4'hB, 4'd3, 4'd7, 4'd2};
    t3_err  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 7; k++) begin
      press(t3_keys[k], e);
      check($sformatf("t3_err_key%0d", k), e, t3_err[k]);
    end
    check("t3_cnt", digit_count, 4);
    run_submit(1'b0);
    check_stream("t3", 4'd1, 4'd5, 4'd3, 4'd7);

    // T4: everything is ignored while locked.
    lock_in = 1'b1;
    press4(4'd1, 4'd5, 4'd3, 4'd7, e);
    check("t4_key_err", e, 0);
    check("t4_cnt", digit_count, 0);
    run_submit(1'b1);
    check("t4_pulses", count_en(), 0);
    check("t4_errs", count_err(), 0);
    check("t4_cnt_after", digit_count, 0);
    lock_in = 1'b0;

    // T5: reset in the middle of a stream.
    press4(4'd1, 4'd5, 4'd3, 4'd7, e);
    @(negedge clk);
    submit_raw = 1'b1;
    found = 0;
    for (int c = 0; c < 30 && found == 0; c++) begin
      @(negedge clk);
      if (enter_button) found = 1;
    end
    check("t5_enter_seen", found, 1);
    if (found == 1) begin
      repeat (3) @(negedge clk);
      check("t5_ip_n3", ip_pass, 5);
      rst = 1'b1;
      submit_raw = 1'b0;
      @(negedge clk);
      check("t5_enter", enter_button, 0);
      check("t5_ip", ip_pass, 0);
      check("t5_busy", busy, 0);
      check("t5_cnt", digit_count, 0);
    end
    rst = 1'b0;
    submit_raw = 1'b0;
    repeat (10) @(negedge clk);
    check("t5_cnt_after", digit_count, 0);

`ifdef ENTRY_TIMEOUT_EN
    // T6: a lone digit times out after 30 idle cycles.
    press(4'd4, e);
    errs = 0;
    for (int c = 0; c < 29; c++) begin
      @(negedge clk);
      if (entry_err) errs++;
    end
    check("t6_cnt_before", digit_count, 1);
    @(negedge clk);
    if (entry_err) errs++;
    check("t6_cnt_after", digit_count, 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (entry_err) errs++;
    end
    check("t6_err_pulses", errs, 1);
`else
    // Without the timeout a partial entry persists.
    press(4'd4, e);
    errs = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (entry_err) errs++;
    end
    check("persist_cnt", digit_count, 1);
    check("persist_errs", errs, 0);
    press(4'hC, e);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
